// File: rtl/z80_arb_pkg.sv
// z80_arb_pkg: shared types and constants for the Z80 memory-port arbiter.
// Rev 1.0
`default_nettype none

package z80_arb_pkg;

  localparam int ARB_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/z80_bus_arbiter_counter.sv
// arb_down_counter: loadable down counter that saturates at zero, with zero/one flags.
// Rev 1.0
`default_nettype none

module arb_down_counter
  import z80_arb_pkg::*;
#(
  parameter int WIDTH = ARB_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             one
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);
  assign one  = (r_count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter: shares system memory between the CPU and one DMA requester via BUSRQ/BUSAK.
// Rev 1.0
`default_nettype none

module z80_bus_arbiter
  import z80_arb_pkg::*;
#(
  parameter int MAX_HOLD = 100,
  parameter int GAP      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        cpu_busrq_n,
  input  logic        cpu_busak_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_mreq_n,
  input  logic        cpu_wr_n,
  input  logic        dma_req,
  output logic        dma_gnt,
  input  logic [15:0] dma_a,
  input  logic [7:0]  dma_do,
  input  logic        dma_we,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        forced_rel
);

  localparam logic [ARB_CNT_W-1:0] C_MAX_HOLD = ARB_CNT_W'(MAX_HOLD);
  localparam logic [ARB_CNT_W-1:0] C_GAP      = ARB_CNT_W'(GAP);

  arb_state_t r_state;
  arb_state_t w_next;

  logic r_busrq_n;
  logic r_gnt;
  logic r_forced;

  logic w_hold_load;
  logic w_hold_dec;
  logic w_hold_zero;
  logic w_hold_one;
  logic w_hold_expire;
  logic w_gap_load;
  logic w_gap_dec;
  logic w_gap_zero;
  logic w_gap_one;
  logic w_forced;

  arb_down_counter #(.WIDTH(ARB_CNT_W)) u_hold_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_hold_load),
    .load_val (C_MAX_HOLD),
    .dec      (w_hold_dec),
    .zero     (w_hold_zero),
    .one      (w_hold_one)
  );

  arb_down_counter #(.WIDTH(ARB_CNT_W)) u_gap_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_gap_load),
    .load_val (C_GAP),
    .dec      (w_gap_dec),
    .zero     (w_gap_zero),
    .one      (w_gap_one)
  );

  assign w_hold_dec    = (r_state == GRANT);
  assign w_gap_dec     = (r_state == IDLE);
  // A hold count of zero means unlimited, so only a live count reaching 1 expires.
  assign w_hold_expire = (MAX_HOLD != 0) && w_hold_one && !w_hold_zero;

  always_comb begin
    w_next      = r_state;
    w_hold_load = 1'b0;
    w_gap_load  = 1'b0;
    w_forced    = 1'b0;
    case (r_state)
      IDLE: begin
        // The final gap count is consumed on the edge that issues the request,
        // so BUSRQ falls exactly GAP cycles after re-entering IDLE.
        if (dma_req && (w_gap_zero || w_gap_one)) begin
          w_next = REQ;
        end
      end
      REQ: begin
        if (!cpu_busak_n) begin
          if (dma_req) begin
            w_next      = GRANT;
            w_hold_load = 1'b1;
          end else begin
            w_next = RELEASE;
          end
        end
      end
      GRANT: begin
        if (!dma_req) begin
          w_next = RELEASE;
        end else if (w_hold_expire) begin
          w_next   = RELEASE;
          w_forced = 1'b1;
        end
      end
      RELEASE: begin
        if (cpu_busak_n) begin
          w_next     = IDLE;
          w_gap_load = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so release and grant take effect on the deciding edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_busrq_n <= 1'b1;
      r_gnt     <= 1'b0;
      r_forced  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_busrq_n <= !((w_next == REQ) || (w_next == GRANT));
      r_gnt     <= (w_next == GRANT);
      r_forced  <= w_forced;
    end
  end

  assign cpu_busrq_n = r_busrq_n;
  assign dma_gnt     = r_gnt;
  assign forced_rel  = r_forced;

  assign mem_a     = r_gnt ? dma_a  : cpu_a;
  assign mem_wdata = r_gnt ? dma_do : cpu_do;
  assign mem_we    = r_gnt ? dma_we : (!cpu_mreq_n && !cpu_wr_n);

endmodule

`default_nettype wire

// File: tb/tb_z80_bus_arbiter.sv
// tb_z80_bus_arbiter: directed self-checking bench for z80_bus_arbiter (MAX_HOLD=8, GAP=4).
// Rev 1.0
`default_nettype none

module tb_z80_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_busrq_n;
  logic        cpu_busak_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_mreq_n;
  logic        cpu_wr_n;
  logic        dma_req;
  logic        dma_gnt;
  logic [15:0] dma_a;
  logic [7:0]  dma_do;
  logic        dma_we;
  logic [15:0] mem_a;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        forced_rel;

  logic [7:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  z80_bus_arbiter #(.MAX_HOLD(8), .GAP(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_busrq_n (cpu_busrq_n),
    .cpu_busak_n (cpu_busak_n),
    .cpu_a       (cpu_a),
    .cpu_do      (cpu_do),
    .cpu_mreq_n  (cpu_mreq_n),
    .cpu_wr_n    (cpu_wr_n),
    .dma_req     (dma_req),
    .dma_gnt     (dma_gnt),
    .dma_a       (dma_a),
    .dma_do      (dma_do),
    .dma_we      (dma_we),
    .mem_a       (mem_a),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .forced_rel  (forced_rel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    cpu_busak_n = 1'b1;
    cpu_a       = 16'h0123;
    cpu_do      = 8'h00;
    cpu_mreq_n  = 1'b1;
    cpu_wr_n    = 1'b1;
    dma_req     = 1'b0;
    dma_a       = 16'h0000;
    dma_do      = 8'h00;
    dma_we      = 1'b0;
    mem[16'h43F8] = 8'h00;
    mem[16'h1000] = 8'h00;
    mem[16'h2000] = 8'h00;
    wait_cycles(2);
    checks++;
    if (cpu_busrq_n !== 1'b1) begin errors++; $display("FAIL reset_busrq: got %b expected 1", cpu_busrq_n); end
    checks++;
    if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", dma_gnt); end
    checks++;
    if (forced_rel !== 1'b0) begin errors++; $display("FAIL reset_forced: got %b expected 0", forced_rel); end
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++;
    if (mem_a !== 16'h0123) begin errors++; $display("FAIL reset_mem_a: got %h expected 0123", mem_a); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_cpu_write();
    cpu_a      = 16'h43F8;
    cpu_do     = 8'hAF;
    cpu_mreq_n = 1'b0;
    cpu_wr_n   = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL cpu_mem_we: got %b expected 1", mem_we); end
    checks++;
    if (mem_wdata !== 8'hAF) begin errors++; $display("FAIL cpu_mem_wdata: got %h expected af", mem_wdata); end
    tick();
    cpu_mreq_n = 1'b1;
    cpu_wr_n   = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL cpu_mem_we_off: got %b expected 0", mem_we); end
    checks++;
    if (mem[16'h43F8] !== 8'hAF) begin errors++; $display("FAIL cpu_mem_43f8: got %h expected af", mem[16'h43F8]); end
    checks++;
    if (cpu_busrq_n !== 1'b1) begin errors++; $display("FAIL cpu_busrq_idle: got %b expected 1", cpu_busrq_n); end
  endtask

  task automatic test_dma_grant();
    dma_req = 1'b1;
    tick();
    checks++;
    if (cpu_busrq_n !== 1'b0) begin errors++; $display("FAIL grant_busrq_fall: got %b expected 0", cpu_busrq_n); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (dma_gnt !== 1'b0 || cpu_busrq_n !== 1'b0) begin
        errors++; $display("FAIL grant_wait_ack: gnt %b busrq %b expected 0 0", dma_gnt, cpu_busrq_n);
      end
    end
    cpu_busak_n = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dma_gnt !== 1'b1) begin errors++; $display("FAIL grant_cycle%0d: gnt %b expected 1", i, dma_gnt); end
      if (i == 0) begin
        dma_a  = 16'h1000;
        dma_do = 8'h55;
        dma_we = 1'b1;
        #1;
        checks++;
        if (mem_a !== 16'h1000 || mem_we !== 1'b1) begin
          errors++; $display("FAIL grant_mux: mem_a %h we %b expected 1000 1", mem_a, mem_we);
        end
      end else begin
        dma_we = 1'b0;
      end
      if (i == 4) dma_req = 1'b0;
      tick();
    end
    checks++;
    if (dma_gnt !== 1'b0 || cpu_busrq_n !== 1'b1) begin
      errors++; $display("FAIL grant_release_edge: gnt %b busrq %b expected 0 1", dma_gnt, cpu_busrq_n);
    end
    checks++;
    if (mem[16'h1000] !== 8'h55) begin errors++; $display("FAIL grant_mem_1000: got %h expected 55", mem[16'h1000]); end
    checks++;
    if (forced_rel !== 1'b0) begin errors++; $display("FAIL grant_no_forced: got %b expected 0", forced_rel); end
    cpu_busak_n = 1'b1;
    wait_cycles(7);
  endtask

  task automatic test_forced_release();
    int gnt_cycles;
    int gap_cycles;
    dma_req = 1'b1;
    tick();
    cpu_busak_n = 1'b0;
    tick();
    gnt_cycles = 0;
    while (dma_gnt === 1'b1 && gnt_cycles < 50) begin
      gnt_cycles++;
      tick();
    end
    checks++;
    if (gnt_cycles != 8) begin errors++; $display("FAIL forced_hold_len: got %0d cycles expected 8", gnt_cycles); end
    checks++;
    if (forced_rel !== 1'b1) begin errors++; $display("FAIL forced_pulse: got %b expected 1", forced_rel); end
    checks++;
    if (cpu_busrq_n !== 1'b1) begin errors++; $display("FAIL forced_busrq: got %b expected 1", cpu_busrq_n); end
    cpu_busak_n = 1'b1;
    tick();
    checks++;
    if (forced_rel !== 1'b0) begin errors++; $display("FAIL forced_pulse_width: got %b expected 0", forced_rel); end
    gap_cycles = 0;
    while (cpu_busrq_n === 1'b1 && gap_cycles < 20) begin
      tick();
      gap_cycles++;
    end
    checks++;
    if (gap_cycles != 4) begin errors++; $display("FAIL forced_gap: got %0d cycles expected 4", gap_cycles); end
    dma_req     = 1'b0;
    cpu_busak_n = 1'b0;
    tick();
    cpu_busak_n = 1'b1;
    wait_cycles(7);
  endtask

  task automatic test_abort();
    logic saw_gnt;
    saw_gnt = 1'b0;
    dma_req = 1'b1;
    tick();
    checks++;
    if (cpu_busrq_n !== 1'b0) begin errors++; $display("FAIL abort_busrq_fall: got %b expected 0", cpu_busrq_n); end
    dma_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (dma_gnt !== 1'b0) saw_gnt = 1'b1;
    end
    checks++;
    if (cpu_busrq_n !== 1'b0) begin errors++; $display("FAIL abort_hold_req: got %b expected 0", cpu_busrq_n); end
    cpu_busak_n = 1'b0;
    tick();
    if (dma_gnt !== 1'b0) saw_gnt = 1'b1;
    checks++;
    if (cpu_busrq_n !== 1'b1) begin errors++; $display("FAIL abort_release: busrq %b expected 1", cpu_busrq_n); end
    tick();
    if (dma_gnt !== 1'b0) saw_gnt = 1'b1;
    cpu_busak_n = 1'b1;
    tick();
    if (dma_gnt !== 1'b0) saw_gnt = 1'b1;
    checks++;
    if (saw_gnt !== 1'b0) begin errors++; $display("FAIL abort_no_gnt: saw gnt %b expected 0", saw_gnt); end
    wait_cycles(6);
  endtask

  task automatic test_reset_mid_grant();
    dma_req = 1'b1;
    tick();
    cpu_busak_n = 1'b0;
    tick();
    checks++;
    if (dma_gnt !== 1'b1) begin errors++; $display("FAIL rst_pre_gnt: got %b expected 1", dma_gnt); end
    dma_a  = 16'h2000;
    dma_do = 8'h77;
    dma_we = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (dma_gnt !== 1'b0 || cpu_busrq_n !== 1'b1) begin
      errors++; $display("FAIL rst_async: gnt %b busrq %b expected 0 1", dma_gnt, cpu_busrq_n);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_a !== cpu_a) begin
      errors++; $display("FAIL rst_mux: mem_we %b mem_a %h expected 0 %h", mem_we, mem_a, cpu_a);
    end
    tick();
    checks++;
    if (mem[16'h2000] !== 8'h00) begin errors++; $display("FAIL rst_no_write: got %h expected 00", mem[16'h2000]); end
    checks++;
    if (forced_rel !== 1'b0) begin errors++; $display("FAIL rst_forced: got %b expected 0", forced_rel); end
    dma_we      = 1'b0;
    cpu_busak_n = 1'b1;
    reset_n     = 1'b1;
    tick();
    dma_req = 1'b1;
    tick();
    checks++;
    if (cpu_busrq_n !== 1'b0) begin errors++; $display("FAIL rst_idle_req: busrq %b expected 0", cpu_busrq_n); end
    dma_req     = 1'b0;
    cpu_busak_n = 1'b0;
    tick();
    cpu_busak_n = 1'b1;
    wait_cycles(7);
  endtask

  task automatic test_unsolicited_ack();
    cpu_a       = 16'h1234;
    dma_a       = 16'hBEEF;
    dma_we      = 1'b1;
    cpu_busak_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dma_gnt !== 1'b0 || mem_a !== 16'h1234 || mem_we !== 1'b0) begin
        errors++; $display("FAIL unsolicited_ack%0d: gnt %b mem_a %h we %b expected 0 1234 0", i, dma_gnt, mem_a, mem_we);
      end
    end
    checks++;
    if (cpu_busrq_n !== 1'b1) begin errors++; $display("FAIL unsolicited_busrq: got %b expected 1", cpu_busrq_n); end
    dma_we      = 1'b0;
    cpu_busak_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_dma_grant();
    test_forced_release();
    test_abort();
    test_reset_mid_grant();
    test_unsolicited_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
